fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
//   Holds the PC, drives the instruction-memory address, and latches the fetched word and PC+4.
//   Applies stall and redirect (JR/J/branch) requests.
//   Feeds id_op (= id_instr[31:26]) directly to the main control decoder in ID.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value loaded on reset
//   NOP_WORD  32'h0000_0000  word inserted into IF/ID on flush (sll $0,$0,0)
// PORTS
//   clk          in   1   single core clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   stall        in   1   hold PC and IF/ID (load-use hazard from ID)
//   br_taken     in   1   branch in ID resolved taken (B from control & compare true)
//   br_target    in   32  branch target computed in ID
//   j            in   1   J/JAL decoded in ID (J output of control)
//   jr           in   1   JR/JALR decoded in ID
//   jr_target    in   32  forwarded rs value for JR
//   imem_addr    out  32  instruction memory address (combinational = pc)
//   imem_rdata   in   32  instruction word, combinational read of imem_addr
//   id_instr     out  32  IF/ID instruction register
//   id_pc4       out  32  IF/ID PC+4 register (link value / branch base)
//   id_valid     out  1   IF/ID holds a real instruction (0 = bubble)
//   id_op        out  6   id_instr[31:26], to control decoder
//   fetch_cnt    out  32  count of instructions latched into IF/ID with valid=1
// BEHAVIOUR
//   Reset (async, any time, including mid-stall or mid-redirect):
//     pc=RESET_PC, id_instr=NOP_WORD, id_pc4=0, id_valid=0, fetch_cnt=0.
//   Release: the first valid word appears in IF/ID one clock edge after rst deasserts.
//   Redirect target, priority jr > j > br_taken:
//     jr:       jr_target
//     j:        {id_pc4[31:28], id_instr[25:0], 2'b00}
//     br_taken: br_target
//   redirect = jr | j | br_taken.
//   Each rising edge, in priority order:
//     1. redirect: pc <= target; IF/ID <= {NOP_WORD, pc+4, valid=0}.
//        No delay slot; the wrong-path word is squashed.
//        Redirect overrides stall; the jump/branch is already resolved in ID.
//     2. stall & !redirect: pc, IF/ID and fetch_cnt all hold.
//     3. else: pc <= pc+4; IF/ID <= {imem_rdata, pc+4, valid=1};
//        fetch_cnt <= fetch_cnt+1.
//   Latency: fetched word is visible on id_instr/id_op one cycle after its address is on imem_addr.
//   Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
//     fetch_cnt wraps 32'hFFFF_FFFF -> 0.
//   Low bits: pc[1:0] is always 0; target[1:0] is forced to 2'b00 when loaded.
//   Flushed bubbles: id_op = 6'b000000 (R-type) with funct=sll, $0 dest, so the bubble is
//     architecturally harmless. id_valid=0 lets downstream gate RegWr/MenWr anyway.
//   Redirect with id_valid=0: redirect inputs are only honoured when id_valid=1.
//     Stale decode of a bubble must never redirect.
// STRUCTURE
//   Shared package mips_pkg: RESET_PC default, NOP_WORD, OP_* opcode constants,
//     typedef if_id_t {instr, pc4, valid}.
//   One sub-module: pc_next_sel, the combinational priority mux computing target/redirect.
//   Registers (pc, IF/ID, fetch_cnt) live in fetch_stage.
// TESTING
//   1. Reset: rst=1 mid-run -> imem_addr=32'h3000, id_valid=0, fetch_cnt=0 immediately (no clock).
//   2. Sequential: rdata=addr-derived, no stall, 4 cycles ->
//      id_pc4 = 3004,3008,300C,3010; fetch_cnt=4.
//   3. Stall: assert stall 2 cycles at pc=3008 -> pc, id_instr and fetch_cnt hold;
//      resume at 3008.
//   4. Jump: id_instr=0x08000C10 (J), id_pc4=3010, id_valid=1 -> next pc=0x00003040;
//      IF/ID bubble (valid=0, instr=0).
//   5. Priority: jr=1 (jr_target=0x4000), j=1 and br_taken=1 (br_target=0x5000), plus stall=1
//      -> pc=0x4000, IF/ID flushed.
//   6. Wrap: force pc=32'hFFFF_FFFC -> next pc=0, id_pc4=0.
//      Bubble with br_taken=1, id_valid=0 -> no redirect.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset/NOP defaults, opcodes,
// and the IF/ID pipeline bundle.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ID redirect/stall requests, imem port,
// and the IF/ID register outputs.
interface fetch_stage_if;

  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, br_taken, br_target,
    input  j, jr, jr_target, imem_rdata,
    output imem_addr, id_instr, id_pc4,
    output id_valid, id_op, fetch_cnt
  );

  modport slave (
    output stall, br_taken, br_target,
    output j, jr, jr_target, imem_rdata,
    input  imem_addr, id_instr, id_pc4,
    input  id_valid, id_op, fetch_cnt
  );

endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Redirect priority mux: jr > j > br_taken, gated by a
// valid IF/ID so a bubble's stale decode never redirects.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic        id_valid,
  input  logic        jr,
  input  logic        j,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  input  logic [31:0] br_target,
  input  logic [3:0]  pc_hi,
  input  logic [25:0] jidx,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    if (jr)
      raw = jr_target;
    else if (j)
      raw = {pc_hi, jidx, 2'b00};
    else if (br_taken)
      raw = br_target;
  end

  assign redirect = id_valid & (jr | j | br_taken);
  assign target   = word_align(raw);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address, IF/ID
// register and a count of valid fetches.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] cnt;
  if_id_t      if_id;
  logic        redirect;
  logic [31:0] target;

  assign pc4 = pc + 32'd4;

  pc_next_sel u_sel (
    .id_valid  (if_id.valid),
    .jr        (bus.jr),
    .j         (bus.j),
    .br_taken  (bus.br_taken),
    .jr_target (bus.jr_target),
    .br_target (bus.br_target),
    .pc_hi     (if_id.pc4[31:28]),
    .jidx      (if_id.instr[25:0]),
    .redirect  (redirect),
    .target    (target)
  );

  // Redirect wins over stall: the branch is already resolved in ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= word_align(RESET_PC);
      if_id.instr <= NOP_WORD;
      if_id.pc4   <= '0;
      if_id.valid <= 1'b0;
      cnt         <= '0;
    end else if (redirect) begin
      pc          <= target;
      if_id.instr <= NOP_WORD;
      if_id.pc4   <= pc4;
      if_id.valid <= 1'b0;
    end else if (!bus.stall) begin
      pc          <= pc4;
      if_id.instr <= bus.imem_rdata;
      if_id.pc4   <= pc4;
      if_id.valid <= 1'b1;
      cnt         <= cnt + 32'd1;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.id_instr  = if_id.instr;
  assign bus.id_pc4    = if_id.pc4;
  assign bus.id_valid  = if_id.valid;
  assign bus.id_op     = if_id.instr[31:26];
  assign bus.fetch_cnt = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table with an IF/ID
// scoreboard, plus async reset hand sequences.
module tb_fetch_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h0000_300C) return 32'h0800_0C10;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign bus.imem_rdata = rd(bus.imem_addr);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic chk_ifid(input string nm,
                          input if_id_t e);
    chk({nm, " instr"}, bus.id_instr, e.instr);
    chk({nm, " pc4"}, bus.id_pc4, e.pc4);
    chk({nm, " valid"}, {31'd0, bus.id_valid},
        {31'd0, e.valid});
    chk({nm, " op"}, {26'd0, bus.id_op},
        {26'd0, e.instr[31:26]});
  endtask

  typedef struct {
    logic        stall;
    logic        jr;
    logic        j;
    logic        br;
    logic [31:0] jr_t;
    logic [31:0] br_t;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    int          kind; // 0 latch, 1 flush, 2 hold
  } vec_t;

  vec_t   v[14];
  if_id_t sb[$];
  if_id_t last;
  if_id_t e;
  logic [31:0] cur_pc;

  initial begin
    v[0]  = '{0,0,0,0, 0, 0, 32'h3004, 1, 0};
    v[1]  = '{0,0,0,0, 0, 0, 32'h3008, 2, 0};
    v[2]  = '{1,0,0,0, 0, 0, 32'h3008, 2, 2};
    v[3]  = '{1,0,0,0, 0, 0, 32'h3008, 2, 2};
    v[4]  = '{0,0,0,0, 0, 0, 32'h300C, 3, 0};
    v[5]  = '{0,0,0,0, 0, 0, 32'h3010, 4, 0};
    v[6]  = '{0,0,1,0, 0, 0, 32'h3040, 4, 1};
    v[7]  = '{0,0,0,1, 0, 32'h5000, 32'h3044, 5, 0};
    v[8]  = '{1,1,1,1, 32'h4000, 32'h5000,
              32'h4000, 5, 1};
    v[9]  = '{0,0,0,0, 0, 0, 32'h4004, 6, 0};
    v[10] = '{0,1,0,0, 32'hFFFF_FFFF, 0,
              32'hFFFF_FFFC, 6, 1};
    v[11] = '{0,0,0,0, 0, 0, 32'h0000_0000, 7, 0};
    v[12] = '{1,0,0,1, 0, 32'h6002, 32'h6000, 7, 1};
    v[13] = '{0,0,0,0, 0, 0, 32'h6004, 8, 0};

    bus.stall = 0; bus.jr = 0; bus.j = 0;
    bus.br_taken = 0;
    bus.jr_target = 0; bus.br_target = 0;

    @(posedge clk); #1;
    chk("rst pc", bus.imem_addr, 32'h3000);
    chk("rst cnt", bus.fetch_cnt, 0);
    chk_ifid("rst", '{32'h0, 32'h0, 1'b0});

    @(negedge clk);
    rst = 1'b0;
    cur_pc = 32'h3000;
    last = '{32'h0, 32'h0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      bus.stall     = v[i].stall;
      bus.jr        = v[i].jr;
      bus.j         = v[i].j;
      bus.br_taken  = v[i].br;
      bus.jr_target = v[i].jr_t;
      bus.br_target = v[i].br_t;
      case (v[i].kind)
        0: e = '{rd(cur_pc), cur_pc + 32'd4, 1'b1};
        1: e = '{32'h0, cur_pc + 32'd4, 1'b0};
        default: e = last;
      endcase
      sb.push_back(e);
      last = e;
      cur_pc = v[i].exp_pc;
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d pc", i),
          bus.imem_addr, v[i].exp_pc);
      chk($sformatf("v%0d cnt", i),
          bus.fetch_cnt, v[i].exp_cnt);
      chk_ifid($sformatf("v%0d", i), e);
      @(negedge clk);
    end

    // async reset in the middle of a stalled redirect
    bus.stall = 1; bus.jr = 1;
    bus.jr_target = 32'h7000;
    #2 rst = 1'b1;
    #1;
    chk("arst pc", bus.imem_addr, 32'h3000);
    chk("arst cnt", bus.fetch_cnt, 0);
    chk_ifid("arst", '{32'h0, 32'h0, 1'b0});

    @(negedge clk);
    bus.stall = 0; bus.jr = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel pc", bus.imem_addr, 32'h3004);
    chk("rel cnt", bus.fetch_cnt, 1);
    chk_ifid("rel",
             '{32'h5A5A_3000, 32'h3004, 1'b1});

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
